// File: rtl/uart_rx.sv
// UART receiver with per-frame oversampling ratio, optional even/odd parity
// and a 3-sample majority vote in the middle of every bit.
// Status outputs are single-cycle pulses raised in the clock after the stop bit.
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stp_Err
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        OUT
    } state_e;

    state_e                state_q, state_d;
    logic [5:0]            edgeCnt_q, edgeCnt_d;
    logic [BCW-1:0]        bitCnt_q, bitCnt_d;
    logic [5:0]            presc_q, presc_d;
    logic                  parEn_q, parEn_d;
    logic                  parTyp_q, parTyp_d;
    logic [DATA_WIDTH-1:0] pData_q, pData_d;
    logic                  parFlag_q, parFlag_d;
    logic                  stpFlag_q, stpFlag_d;
    logic                  sample0_q, sample0_d;
    logic                  sample1_q, sample1_d;
    logic                  voted_q, voted_d;
    logic                  dataValid_q, dataValid_d;
    logic                  parErr_q, parErr_d;
    logic                  stpErr_q, stpErr_d;

    logic [5:0]            prescEff;
    logic [5:0]            half;
    logic                  lastEdge;
    logic                  voteEdge;
    logic                  vote;

    // Unsupported oversampling ratios fall back to 8 clocks per bit.
    always_comb begin
        prescEff = 6'd8;
        if (Prescale == 6'd8 || Prescale == 6'd16 || Prescale == 6'd32) begin
            prescEff = Prescale;
        end
    end

    assign half     = {1'b0, presc_q[5:1]};
    assign lastEdge = (edgeCnt_q == presc_q - 6'd1);
    assign voteEdge = (edgeCnt_q == half + 6'd1);
    assign vote     = (sample0_q & sample1_q) | (sample0_q & RX_IN) | (sample1_q & RX_IN);

    // Next-state logic: bit timing, sampling, payload assembly and flag/pulse generation.
    always_comb begin
        state_d     = state_q;
        edgeCnt_d   = edgeCnt_q;
        bitCnt_d    = bitCnt_q;
        presc_d     = presc_q;
        parEn_d     = parEn_q;
        parTyp_d    = parTyp_q;
        pData_d     = pData_q;
        parFlag_d   = parFlag_q;
        stpFlag_d   = stpFlag_q;
        sample0_d   = sample0_q;
        sample1_d   = sample1_q;
        voted_d     = voted_q;
        dataValid_d = 1'b0;
        parErr_d    = 1'b0;
        stpErr_d    = 1'b0;

        if (state_q == START || state_q == DATA || state_q == PARITY || state_q == STOP) begin
            edgeCnt_d = lastEdge ? 6'd0 : edgeCnt_q + 6'd1;
            if (edgeCnt_q == half - 6'd1) begin
                sample0_d = RX_IN;
            end
            if (edgeCnt_q == half) begin
                sample1_d = RX_IN;
            end
            if (voteEdge) begin
                voted_d = vote;
            end
        end

        case (state_q)
            IDLE, OUT: begin
                edgeCnt_d = 6'd0;
                state_d   = IDLE;
                if (!RX_IN) begin
                    state_d   = START;
                    bitCnt_d  = '0;
                    parFlag_d = 1'b0;
                    stpFlag_d = 1'b0;
                    presc_d   = prescEff;
                    parEn_d   = PAR_EN;
                    parTyp_d  = PAR_TYP;
                end
            end
            START: begin
                if (lastEdge) begin
                    state_d = voted_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (voteEdge) begin
                    pData_d[bitCnt_q] = vote;
                end
                if (lastEdge) begin
                    if (bitCnt_q == BCW'(DATA_WIDTH - 1)) begin
                        bitCnt_d = '0;
                        state_d  = parEn_q ? PARITY : STOP;
                    end else begin
                        bitCnt_d = bitCnt_q + BCW'(1);
                    end
                end
            end
            PARITY: begin
                if (voteEdge) begin
                    parFlag_d = vote ^ (^pData_q) ^ parTyp_q;
                end
                if (lastEdge) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (voteEdge) begin
                    stpFlag_d = ~vote;
                end
                if (lastEdge) begin
                    state_d     = OUT;
                    dataValid_d = ~parFlag_q & ~stpFlag_q;
                    parErr_d    = parFlag_q;
                    stpErr_d    = stpFlag_q;
                end
            end
            default: begin
                state_d   = IDLE;
                edgeCnt_d = 6'd0;
            end
        endcase
    end

    // State register with synchronous active-low reset that aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            edgeCnt_q   <= 6'd0;
            bitCnt_q    <= '0;
            presc_q     <= 6'd8;
            parEn_q     <= 1'b0;
            parTyp_q    <= 1'b0;
            pData_q     <= '0;
            parFlag_q   <= 1'b0;
            stpFlag_q   <= 1'b0;
            sample0_q   <= 1'b1;
            sample1_q   <= 1'b1;
            voted_q     <= 1'b1;
            dataValid_q <= 1'b0;
            parErr_q    <= 1'b0;
            stpErr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            edgeCnt_q   <= edgeCnt_d;
            bitCnt_q    <= bitCnt_d;
            presc_q     <= presc_d;
            parEn_q     <= parEn_d;
            parTyp_q    <= parTyp_d;
            pData_q     <= pData_d;
            parFlag_q   <= parFlag_d;
            stpFlag_q   <= stpFlag_d;
            sample0_q   <= sample0_d;
            sample1_q   <= sample1_d;
            voted_q     <= voted_d;
            dataValid_q <= dataValid_d;
            parErr_q    <= parErr_d;
            stpErr_q    <= stpErr_d;
        end
    end

    assign P_DATA     = pData_q;
    assign Data_Valid = dataValid_q;
    assign Par_Err    = parErr_q;
    assign Stp_Err    = stpErr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// compared against a frame-level reference model.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxIn;
    logic [5:0] prescaleIn;
    logic       parEnIn;
    logic       parTypIn;
    logic [7:0] pData;
    logic       dataValid;
    logic       parErr;
    logic       stpErr;

    int checks = 0;
    int errors = 0;
    int cycleCnt = 0;
    int stopEnd = 0;

    typedef struct {
        int         cyc;
        logic [10:0] info;
    } ev_t;

    ev_t evQ[$];

    uart_rx #(.DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .RX_IN     (rxIn),
        .Prescale  (prescaleIn),
        .PAR_EN    (parEnIn),
        .PAR_TYP   (parTypIn),
        .P_DATA    (pData),
        .Data_Valid(dataValid),
        .Par_Err   (parErr),
        .Stp_Err   (stpErr)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Record every output pulse with its cycle number, sampled just after the edge.
    always @(posedge clk) begin
        ev_t e;
        cycleCnt++;
        #1;
        if (dataValid === 1'b1 || parErr === 1'b1 || stpErr === 1'b1) begin
            e.cyc  = cycleCnt;
            e.info = {dataValid, parErr, stpErr, pData};
            evQ.push_back(e);
        end
    end

    function automatic int effPresc(input int p);
        return (p == 8 || p == 16 || p == 32) ? p : 8;
    endfunction

    function automatic logic goodParity(input logic [7:0] d, input logic pt);
        return logic'($countones(d) % 2) ^ pt;
    endfunction

    // Expected outcome {valid, parity error, stop error, payload} from frame-level rules.
    function automatic logic [10:0] modelFrame(input logic [7:0] d, input logic pe, input logic pt,
                                               input logic parBit, input logic stopV);
        int   ones;
        logic pErr;
        logic sErr;
        ones = $countones(d) + (pe ? int'(parBit) : 0);
        pErr = pe && ((ones % 2) != int'(pt));
        sErr = (stopV == 1'b0);
        return {~pErr & ~sErr, pErr, sErr, d};
    endfunction

    task automatic driveBit(input logic v, input int n);
        rxIn = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rxIn = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drive one complete frame; configuration inputs may be scrambled once the frame has started.
    task automatic sendFrame(input logic [7:0] d, input int prescSet, input logic pe, input logic pt,
                             input logic parBit, input logic stopV, input logic scramble);
        int n;
        n          = effPresc(prescSet);
        prescaleIn = 6'(prescSet);
        parEnIn    = pe;
        parTypIn   = pt;
        driveBit(1'b0, n);
        if (scramble) begin
            prescaleIn = 6'($urandom);
            parEnIn    = 1'($urandom);
            parTypIn   = 1'($urandom);
        end
        for (int i = 0; i < 8; i++) begin
            driveBit(d[i], n);
        end
        if (pe) begin
            driveBit(parBit, n);
        end
        driveBit(stopV, n);
        stopEnd = cycleCnt;
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        rxIn       = 1'b1;
        prescaleIn = 6'd8;
        parEnIn    = 1'b0;
        parTypIn   = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({dataValid, parErr, stpErr, pData} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %h want 000", {dataValid, parErr, stpErr, pData});
        end
        rst = 1'b1;
        idle(4);
        evQ.delete();
    endtask

    task automatic test_odd_parity_p8();
        logic [10:0] exp;
        evQ.delete();
        sendFrame(8'hCD, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(4);
        exp = modelFrame(8'hCD, 1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (evQ.size() !== 1) begin
            errors++;
            $display("[TB] FAIL odd8_pulses got %0d want 1", evQ.size());
        end else begin
            checks++;
            if (evQ[0].info !== exp) begin
                errors++;
                $display("[TB] FAIL odd8_info got %h want %h", evQ[0].info, exp);
            end
            checks++;
            if (evQ[0].cyc !== stopEnd + 1) begin
                errors++;
                $display("[TB] FAIL odd8_latency got %0d want %0d", evQ[0].cyc, stopEnd + 1);
            end
        end
    endtask

    task automatic test_parity_error_p16();
        logic [10:0] exp;
        evQ.delete();
        sendFrame(8'hC9, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(4);
        exp = modelFrame(8'hC9, 1'b1, 1'b0, 1'b1, 1'b1);
        checks++;
        if (evQ.size() !== 1) begin
            errors++;
            $display("[TB] FAIL parerr_pulses got %0d want 1", evQ.size());
        end else begin
            checks++;
            if (evQ[0].info !== exp) begin
                errors++;
                $display("[TB] FAIL parerr_info got %h want %h", evQ[0].info, exp);
            end
        end
    endtask

    task automatic test_stop_error();
        logic [10:0] exp [2];
        int          ends [2];
        evQ.delete();
        sendFrame(8'hCD, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        ends[0] = stopEnd;
        idle(4);
        sendFrame(8'h3A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        ends[1] = stopEnd;
        idle(4);
        exp[0] = modelFrame(8'hCD, 1'b0, 1'b0, 1'b0, 1'b0);
        exp[1] = modelFrame(8'h3A, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (evQ.size() !== 2) begin
            errors++;
            $display("[TB] FAIL stoperr_pulses got %0d want 2", evQ.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (evQ[i].info !== exp[i] || evQ[i].cyc !== ends[i] + 1) begin
                    errors++;
                    $display("[TB] FAIL stoperr_frame%0d got %h@%0d want %h@%0d", i, evQ[i].info,
                             evQ[i].cyc, exp[i], ends[i] + 1);
                end
            end
        end
    endtask

    task automatic test_glitch();
        logic [10:0] exp;
        evQ.delete();
        prescaleIn = 6'd8;
        parEnIn    = 1'b0;
        rxIn       = 1'b0;
        repeat (3) @(negedge clk);
        idle(20);
        checks++;
        if (evQ.size() !== 0) begin
            errors++;
            $display("[TB] FAIL glitch_pulses got %0d want 0", evQ.size());
        end
        sendFrame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(4);
        exp = modelFrame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (evQ.size() !== 1 || evQ[0].info !== exp) begin
            errors++;
            $display("[TB] FAIL glitch_next got %0d pulses first %h want 1 pulse %h", evQ.size(),
                     (evQ.size() > 0) ? evQ[0].info : 11'h0, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp;
        int          end0;
        evQ.delete();
        sendFrame(8'hC9, 32, 1'b1, 1'b0, goodParity(8'hC9, 1'b0), 1'b1, 1'b1);
        end0 = stopEnd;
        sendFrame(8'hC9, 32, 1'b1, 1'b0, goodParity(8'hC9, 1'b0), 1'b1, 1'b1);
        idle(6);
        exp = modelFrame(8'hC9, 1'b1, 1'b0, goodParity(8'hC9, 1'b0), 1'b1);
        checks++;
        if (evQ.size() !== 2) begin
            errors++;
            $display("[TB] FAIL b2b_pulses got %0d want 2", evQ.size());
        end else begin
            checks++;
            if (evQ[0].info !== exp || evQ[1].info !== exp) begin
                errors++;
                $display("[TB] FAIL b2b_info got %h %h want %h", evQ[0].info, evQ[1].info, exp);
            end
            checks++;
            if (evQ[0].cyc !== end0 + 1 || evQ[1].cyc < stopEnd + 1 || evQ[1].cyc > stopEnd + 2) begin
                errors++;
                $display("[TB] FAIL b2b_timing got %0d %0d want %0d and %0d..%0d", evQ[0].cyc,
                         evQ[1].cyc, end0 + 1, stopEnd + 1, stopEnd + 2);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0]  d;
        logic [10:0] exp;
        d = 8'h3C;
        evQ.delete();
        prescaleIn = 6'd8;
        parEnIn    = 1'b0;
        parTypIn   = 1'b0;
        driveBit(1'b0, 8);
        for (int i = 0; i < 4; i++) begin
            driveBit(d[i], 8);
        end
        driveBit(d[4], 4);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({dataValid, parErr, stpErr, pData} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL abort_reset_outputs got %h want 000", {dataValid, parErr, stpErr, pData});
        end
        rxIn = 1'b1;
        rst  = 1'b1;
        idle(20);
        checks++;
        if (evQ.size() !== 0) begin
            errors++;
            $display("[TB] FAIL abort_pulses got %0d want 0", evQ.size());
        end
        sendFrame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(4);
        exp = modelFrame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (evQ.size() !== 1 || evQ[0].info !== exp) begin
            errors++;
            $display("[TB] FAIL abort_next got %0d pulses first %h want 1 pulse %h", evQ.size(),
                     (evQ.size() > 0) ? evQ[0].info : 11'h0, exp);
        end
    endtask

    task automatic test_illegal_prescale();
        int          bad [3];
        logic [10:0] exp;
        bad = '{12, 0, 40};
        for (int i = 0; i < 3; i++) begin
            evQ.delete();
            sendFrame(8'h96 + 8'(i), bad[i], 1'b1, 1'b1, goodParity(8'h96 + 8'(i), 1'b1), 1'b1, 1'b1);
            idle(4);
            exp = modelFrame(8'h96 + 8'(i), 1'b1, 1'b1, goodParity(8'h96 + 8'(i), 1'b1), 1'b1);
            checks++;
            if (evQ.size() !== 1 || evQ[0].info !== exp || evQ[0].cyc !== stopEnd + 1) begin
                errors++;
                $display("[TB] FAIL illegal_presc%0d got %0d pulses first %h want 1 pulse %h@%0d",
                         bad[i], evQ.size(), (evQ.size() > 0) ? evQ[0].info : 11'h0, exp, stopEnd + 1);
            end
        end
    endtask

    task automatic test_random();
        int          pList [4];
        int          p;
        logic [7:0]  d;
        logic        pe, pt, pb, sv;
        logic [10:0] exp;
        pList = '{8, 16, 32, 20};
        for (int n = 0; n < 40; n++) begin
            p  = pList[$urandom_range(0, 3)];
            d  = 8'($urandom);
            pe = 1'($urandom);
            pt = 1'($urandom);
            pb = goodParity(d, pt) ^ ($urandom_range(0, 4) == 0);
            sv = ($urandom_range(0, 5) != 0);
            evQ.delete();
            sendFrame(d, p, pe, pt, pb, sv, 1'b1);
            idle(2 + $urandom_range(0, 3));
            exp = modelFrame(d, pe, pt, pb, sv);
            checks++;
            if (evQ.size() !== 1 || evQ[0].info !== exp || evQ[0].cyc !== stopEnd + 1) begin
                errors++;
                $display("[TB] FAIL random%0d p=%0d pe=%0d pt=%0d got %0d pulses first %h@%0d want %h@%0d",
                         n, p, pe, pt, evQ.size(), (evQ.size() > 0) ? evQ[0].info : 11'h0,
                         (evQ.size() > 0) ? evQ[0].cyc : 0, exp, stopEnd + 1);
            end
        end
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        test_reset();
        test_odd_parity_p8();
        test_parity_error_p16();
        test_stop_error();
        test_glitch();
        test_back_to_back();
        test_reset_abort();
        test_illegal_prescale();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: UART_RX

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload bits per frame.
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port RX_IN  input  1  serial line: idle high, start 0, data LSB first, optional parity, stop 1.
REQ-005 SHALL have port Prescale  input  6  oversampling ratio, clocks per bit; legal values 8, 16, 32.
REQ-006 SHALL have port PAR_EN  input  1  1 = frame carries a parity bit.
REQ-007 SHALL have port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 SHALL have port P_DATA  output  DATA_WIDTH  received payload.
REQ-009 SHALL have port Data_Valid  output  1  one-cycle pulse, P_DATA holds a good frame.
REQ-010 SHALL have port Par_Err  output  1  one-cycle pulse, parity mismatch.
REQ-011 SHALL have port Stp_Err  output  1  one-cycle pulse, stop bit sampled 0.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, OUT.
REQ-013 SHALL keep edge_cnt (0..Prescale-1, counts clocks within a bit) and bit_cnt (0..DATA_WIDTH-1); both clear on entry to START.
REQ-014 SHALL, in IDLE, move to START on the first clock with RX_IN = 0; otherwise stay in IDLE.
REQ-015 SHALL sample each bit by 3-sample majority vote at edge_cnt = Prescale/2-1, Prescale/2, Prescale/2+1; the voted value is registered at Prescale/2+1.
REQ-016 SHALL, in START, return to IDLE at edge_cnt = Prescale-1 if the voted start bit is 1 (glitch rejection, no output pulse); else enter DATA.
REQ-017 SHALL, in DATA, shift the voted bit into P_DATA position bit_cnt (LSB first); after bit DATA_WIDTH-1 at edge_cnt = Prescale-1, enter PARITY if PAR_EN = 1, else STOP.
REQ-018 SHALL compute expected parity as XOR of the payload for even, inverted for odd; a mismatch sets an internal par_flag.
REQ-019 SHALL, in STOP, set an internal stp_flag if the voted stop bit is 0, and enter OUT at edge_cnt = Prescale-1.
REQ-020 SHALL, in OUT (exactly one clock): assert Data_Valid iff par_flag = 0 and stp_flag = 0; assert Par_Err iff par_flag; assert Stp_Err iff stp_flag; then go to START if RX_IN = 0 (back-to-back frames), else IDLE.
REQ-021 SHALL hold P_DATA stable from OUT until the next frame's first data bit is captured; P_DATA is not cleared between frames.
REQ-022 SHALL latch PAR_EN, PAR_TYP and Prescale on IDLE->START; changes mid-frame SHALL NOT affect the current frame.
REQ-023 SHALL, for an illegal Prescale value, operate as Prescale = 8.
REQ-024 SHALL treat end-to-end latency as: Data_Valid high exactly one clock after the last clock of the stop bit period.

Reset
REQ-025 SHALL, while rst = 0 at a rising edge, force state IDLE, edge_cnt = 0, bit_cnt = 0, flags = 0, P_DATA = 0, Data_Valid = 0, Par_Err = 0, Stp_Err = 0.
REQ-026 SHALL abort any frame in progress on reset with no output pulse; after release, reception resumes only at the next falling edge of RX_IN.

Verification
REQ-027 SHALL verify: Prescale 8, PAR_EN 1, PAR_TYP 1, frame for 0xCD (parity 0, stop 1) -> Data_Valid pulse 1 clock, P_DATA = 0xCD, Par_Err = Stp_Err = 0, pulse 1 clock after stop bit ends.
REQ-028 SHALL verify: Prescale 16, PAR_EN 1, PAR_TYP 0, 0xC9 sent with parity bit 1 (wrong) -> Par_Err pulse, Data_Valid stays 0.
REQ-029 SHALL verify: Prescale 8, PAR_EN 0, 0xCD with stop bit driven 0 -> Stp_Err pulse, no Data_Valid; following correct frame 0x3A -> Data_Valid, P_DATA = 0x3A.
REQ-030 SHALL verify: RX_IN low for 3 clocks then high (Prescale 8) -> FSM back to IDLE, no pulses; next valid frame 0x55 received correctly.
REQ-031 SHALL verify: two frames 0xC9, 0xC9 even parity back-to-back, no idle gap (Prescale 32) -> two Data_Valid pulses, both P_DATA = 0xC9.
REQ-032 SHALL verify: rst driven 0 during DATA bit 4, released, then frame 0xA5 -> no pulse for aborted frame; 0xA5 received with Data_Valid.
